input_deserializer: RTL
=======================

INPUT_DESERIALIZER -- requirements
Module: input_deserializer

Interface
REQ-001 The module SHALL provide parameter LANE_WIDTH, default 1: the width in bits of each lane sample delivered per enabled cycle by the upstream input I/O register.
REQ-002 The module SHALL provide parameter WORD_LANES, default 8: the number of lanes per assembled word, legal range 1 and up.
REQ-003 The module SHALL use a derived width WORD_WIDTH = LANE_WIDTH*WORD_LANES.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock for all state, sampled on the rising edge.
REQ-005 The module SHALL have port clear_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port clock_enable, input, 1 bit: lane_in and frame_in are valid this cycle.
REQ-007 The module SHALL have port lane_in, input, LANE_WIDTH bits: the lane sample from the input I/O register data_out.
REQ-008 The module SHALL have port frame_in, input, 1 bit: marks lane_in as the first lane of a word.
REQ-009 The module SHALL have port word_out, output, WORD_WIDTH bits: the assembled word.
REQ-010 The module SHALL have port word_out_valid, output, 1 bit: word_out holds an unread word.
REQ-011 The module SHALL have port word_out_ready, input, 1 bit: the consumer accepts word_out.
REQ-012 The module SHALL have port errors_clear, input, 1 bit: clears the sticky error flags.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky; a completed word was dropped.
REQ-014 The module SHALL have port framing_error, output, 1 bit: sticky; a partial word was discarded.

Function
REQ-015 The assembler SHALL have two states: HUNT and ASSEMBLE, with a lane counter of clog2(WORD_LANES+1) bits.
REQ-016 Lanes SHALL be accepted only on cycles with clock_enable=1; when clock_enable=0, the state, counter and partial word SHALL hold.
REQ-017 In HUNT, a lane with frame_in=0 SHALL be ignored without flagging an error.
REQ-018 In HUNT, a lane with frame_in=1 SHALL be stored in lane position 0 and set the count to 1.
REQ-019 The assembler SHALL then move to ASSEMBLE, unless WORD_LANES=1, in which case the word completes.
REQ-020 In ASSEMBLE, a lane with frame_in=0 SHALL be stored at position count and increment the count.
REQ-021 Lane position k SHALL occupy word bits [k*LANE_WIDTH +: LANE_WIDTH], so the first lane is least significant.
REQ-022 In ASSEMBLE, a lane with frame_in=1 SHALL set framing_error and discard the partial word.
REQ-023 That framed lane SHALL restart assembly as position 0, with count 1.
REQ-024 The word SHALL complete on the accepted lane that makes count equal WORD_LANES; the assembler SHALL then return to HUNT with count 0.
REQ-025 word_out_valid SHALL rise on the clock edge that accepts the final lane, so it is visible the next cycle (1-cycle latency from the final lane).
REQ-026 A transfer SHALL occur when word_out_valid=1 and word_out_ready=1 at a clock edge; word_out_valid SHALL then fall unless a word completes on the same edge.
REQ-027 A completed word SHALL load word_out if word_out_valid=0, or if word_out_valid=1 and a transfer occurs on the same edge; in the latter case valid SHALL remain 1.
REQ-028 A completed word arriving while word_out_valid=1 with no transfer SHALL be dropped, overflow SHALL set, and word_out SHALL keep the unread word.
REQ-029 word_out SHALL hold its last value after a transfer until a new word loads.
REQ-030 word_out_valid SHALL NOT depend combinationally on word_out_ready.
REQ-031 errors_clear=1 SHALL clear overflow and framing_error at the next edge.
REQ-032 If an error event coincides with errors_clear, the set SHALL win.
REQ-033 Error flags SHALL NOT alter assembly or output behaviour.

Reset
REQ-034 clear_n=0 at a rising clock edge SHALL force: state HUNT, count 0, partial word 0, word_out 0, word_out_valid 0, overflow 0, framing_error 0.
REQ-035 Reset SHALL take priority over clock_enable, transfers and errors_clear.
REQ-036 A partial word in progress when clear_n=0 SHALL be discarded without setting framing_error.

Verification (LANE_WIDTH=2, WORD_LANES=4 unless noted)
REQ-037 Lanes 0x1,0x2,0x3,0x0 with frame_in on the first lane, ready=1 -> word_out=0x39 with valid high for exactly 1 cycle, one cycle after the 4th lane.
REQ-038 Same lanes with clock_enable toggling 1,0,1,0,... -> same word 0x39, with valid delayed only by the gaps.
REQ-039 Frame, then 2 lanes, then frame again followed by 0x3,0x3,0x3 -> framing_error=1 and a single word 0xFF output.
REQ-040 ready=0, two complete words 0x39 then 0xE4 -> word_out stays 0x39 and overflow=1; after ready=1, one transfer of 0x39 and valid=0.
REQ-041 valid=1 and ready=1 on the same edge as the next word completes -> back-to-back transfer, valid stays 1, no overflow.
REQ-042 clear_n=0 mid-word, then a full framed word 0x39 -> all outputs 0 during reset, no framing_error, correct 0x39 afterwards; with WORD_LANES=1, each framed lane completes immediately.

Source files
------------

// File: rtl/input_deserializer_if.sv
// Lane-in / word-out bundle for input_deserializer.
//   clock_enable   : lane_in/frame_in are valid this cycle (master -> slave)
//   lane_in        : one lane sample from the input I/O register (master -> slave)
//   frame_in       : lane_in is the first lane of a word (master -> slave)
//   word_out       : assembled word, first lane least significant (slave -> master)
//   word_out_valid : word_out holds an unread word (slave -> master)
//   word_out_ready : consumer accepts word_out (master -> slave)
interface input_deserializer_if #(
   parameter int LANE_WIDTH = 1,
   parameter int WORD_LANES = 8
);
   localparam int WORD_WIDTH = LANE_WIDTH * WORD_LANES;

   logic                  clock_enable;
   logic [LANE_WIDTH-1:0] lane_in;
   logic                  frame_in;
   logic [WORD_WIDTH-1:0] word_out;
   logic                  word_out_valid;
   logic                  word_out_ready;

   modport master (
      output clock_enable, lane_in, frame_in, word_out_ready,
      input  word_out, word_out_valid
   );

   modport slave (
      input  clock_enable, lane_in, frame_in, word_out_ready,
      output word_out, word_out_valid
   );
endinterface

// File: rtl/input_deserializer.sv
// Assembles WORD_LANES lane samples into one word with a single-entry
// valid/ready output register and sticky overflow / framing error flags.
//   clock         : single clock, rising edge
//   clear_n       : synchronous active-low reset
//   bus (slave)   : clock_enable, lane_in, frame_in in; word_out, word_out_valid out;
//                   word_out_ready in
//   errors_clear  : clears overflow and framing_error (a coincident set wins)
//   overflow      : sticky, a completed word was dropped
//   framing_error : sticky, a partial word was discarded by an early frame
//
// state    | meaning
// HUNT     | waiting for a lane with frame_in=1; unframed lanes ignored
// ASSEMBLE | collecting lanes 1..WORD_LANES-1 of the current word
module input_deserializer #(
   parameter int LANE_WIDTH = 1,
   parameter int WORD_LANES = 8
) (
   input  logic                      clock,
   input  logic                      clear_n,
   input_deserializer_if.slave       bus,
   input  logic                      errors_clear,
   output logic                      overflow,
   output logic                      framing_error
);
   localparam int WORD_WIDTH = LANE_WIDTH * WORD_LANES;
   localparam int CNT_W      = $clog2(WORD_LANES + 1);

   typedef enum logic {
      HUNT     = 1'b0,
      ASSEMBLE = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] part_q, part_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  ferr_q, ferr_d;

   logic                  complete;
   logic                  frame_evt;
   logic                  xfer;

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= HUNT;
         cnt_q   <= '0;
         part_q  <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         part_q  <= part_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         ferr_q  <= ferr_d;
      end
   end

   // Lane assembly
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      part_d    = part_q;
      complete  = 1'b0;
      frame_evt = 1'b0;

      if (bus.clock_enable) begin
         case (state_q)
            HUNT: begin
               if (bus.frame_in) begin
                  part_d                   = '0;
                  part_d[LANE_WIDTH-1:0]   = bus.lane_in;
                  if (WORD_LANES == 1) begin
                     complete = 1'b1;
                     cnt_d    = '0;
                     state_d  = HUNT;
                  end else begin
                     cnt_d    = CNT_W'(1);
                     state_d  = ASSEMBLE;
                  end
               end
            end
            ASSEMBLE: begin
               if (bus.frame_in) begin
                  // Early frame: drop the partial word and restart from this lane.
                  frame_evt              = 1'b1;
                  part_d                 = '0;
                  part_d[LANE_WIDTH-1:0] = bus.lane_in;
                  cnt_d                  = CNT_W'(1);
               end else begin
                  for (int k = 0; k < WORD_LANES; k++) begin
                     if (cnt_q == CNT_W'(k))
                        part_d[k*LANE_WIDTH +: LANE_WIDTH] = bus.lane_in;
                  end
                  if (cnt_q + CNT_W'(1) == CNT_W'(WORD_LANES)) begin
                     complete = 1'b1;
                     cnt_d    = '0;
                     state_d  = HUNT;
                  end else begin
                     cnt_d    = cnt_q + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = HUNT;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Output register and sticky flags
   always_comb begin
      xfer    = valid_q & bus.word_out_ready;
      word_d  = word_q;
      valid_d = valid_q;
      ovf_d   = errors_clear ? 1'b0 : ovf_q;
      ferr_d  = errors_clear ? 1'b0 : ferr_q;

      if (complete) begin
         if (!valid_q || xfer) begin
            word_d  = part_d;
            valid_d = 1'b1;
         end else begin
            ovf_d   = 1'b1;
         end
      end else if (xfer) begin
         valid_d = 1'b0;
      end

      if (frame_evt)
         ferr_d = 1'b1;
   end

   assign bus.word_out       = word_q;
   assign bus.word_out_valid = valid_q;
   assign overflow           = ovf_q;
   assign framing_error      = ferr_q;
endmodule
